output_port_arbiter: RTL and testbench

OUTPUT_PORT_ARBITER -- requirements
Module: output_port_arbiter

---
 rtl/noc_pkg.sv | 36 +++
 rtl/rr_arbiter5.sv | 28 ++
 rtl/output_port_arbiter.sv | 163 ++++++++++++++++
 tb/tb_output_port_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC router types: port indices, lock states and flit helpers.
// Imported by rr_arbiter5 and output_port_arbiter.
package noc_pkg;

  localparam int NUM_PORTS = 5;

  typedef enum logic [2:0] {
    PORT_N = 3'd0,
    PORT_S = 3'd1,
    PORT_E = 3'd2,
    PORT_W = 3'd3,
    PORT_L = 3'd4
  } port_e;

  typedef enum logic {
    LK_IDLE   = 1'b0,
    LK_LOCKED = 1'b1
  } lock_e;

  // Tail flag is the MSB of a flit.
  function automatic int tail_bit(input int data_w);
    return data_w - 1;
  endfunction

  // (base + off) mod 5, for base and off in 0..4.
  function automatic logic [2:0] wrap5(
    input logic [2:0] base,
    input logic [2:0] off
  );
    logic [3:0] sum;
    sum = {1'b0, base} + {1'b0, off};
    if (sum >= 4'd5) sum = sum - 4'd5;
    return sum[2:0];
  endfunction

endpackage

// File: rtl/rr_arbiter5.sv
// Five-way round-robin selector, purely combinational.
// Ports: req (5 requests), ptr (start index 0-4), grant (one-hot or zero).
import noc_pkg::*;

module rr_arbiter5 (
  input  logic [4:0] req,
  input  logic [2:0] ptr,
  output logic [4:0] grant
);

  logic       found;
  logic [2:0] idx;

  // Walk ptr, ptr+1, ... wrapping 4->0; first requester wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = wrap5(ptr, 3'(i));
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/output_port_arbiter.sv
// Router output port: round-robin arbitration, credit flow control and a
// registered flit stage. Define PKT_LOCK_EN for a wormhole packet lock.
// Ports: clk, rst (async high), req_i/data_i from 5 input queues,
// grant_o pops the winner, credit_i returns slots, valid_o/data_o/src_o
// registered flit, credits_o credit count, err_o sticky credit overflow.
import noc_pkg::*;

module output_port_arbiter #(
  parameter int DATA_W  = 32,
  parameter int CREDITS = 4,
  localparam int CW     = $clog2(CREDITS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4:0]            req_i,
  input  logic [5*DATA_W-1:0]   data_i,
  output logic [4:0]            grant_o,
  input  logic                  credit_i,
  output logic                  valid_o,
  output logic [DATA_W-1:0]     data_o,
  output logic [2:0]            src_o,
  output logic [CW-1:0]         credits_o,
  output logic                  err_o
);

  localparam logic [CW-1:0] CMAX = CW'(CREDITS);

  logic [2:0]        r_ptr;
  logic [CW-1:0]     r_credits;
  logic              r_err;
  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [2:0]        r_src;

  logic [4:0]        w_rr_grant;
  logic [4:0]        w_cand;
  logic [4:0]        w_grant;
  logic              w_gnt;
  logic [DATA_W-1:0] w_sel;
  logic [2:0]        w_src;
  logic              w_ptr_en;

  rr_arbiter5 u_rr (
    .req   (req_i),
    .ptr   (r_ptr),
    .grant (w_rr_grant)
  );

`ifdef PKT_LOCK_EN
  localparam int TB = tail_bit(DATA_W);

  lock_e      r_state;
  lock_e      w_state_nxt;
  logic [2:0] r_lock_port;
  logic [2:0] w_lock_port_nxt;
  logic       w_tail;

  // While locked only the owning port can win.
  always_comb begin
    w_cand = w_rr_grant;
    if (r_state == LK_LOCKED)
      w_cand = req_i & (5'b00001 << r_lock_port);
  end
`else
  assign w_cand = w_rr_grant;
`endif

  // A credit arriving this cycle is not visible until r_credits updates.
  assign w_grant = (rst || r_credits == '0) ? '0 : w_cand;
  assign w_gnt   = |w_grant;
  assign grant_o = w_grant;

  always_comb begin
    w_sel = '0;
    w_src = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (w_grant[k]) begin
        w_sel = data_i[k*DATA_W +: DATA_W];
        w_src = 3'(k);
      end
    end
  end

`ifdef PKT_LOCK_EN
  assign w_tail   = w_sel[TB];
  // Pointer only moves once a whole packet has gone.
  assign w_ptr_en = w_gnt && w_tail;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= LK_IDLE;
      r_lock_port <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_lock_port <= w_lock_port_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_lock_port_nxt = r_lock_port;
    unique case (r_state)
      LK_IDLE: begin
        if (w_gnt && !w_tail) begin
          w_state_nxt     = LK_LOCKED;
          w_lock_port_nxt = w_src;
        end
      end
      LK_LOCKED: begin
        if (w_gnt && w_tail)
          w_state_nxt = LK_IDLE;
      end
      default: w_state_nxt = LK_IDLE;
    endcase
  end
`else
  assign w_ptr_en = w_gnt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_ptr_en) begin
      r_ptr <= wrap5(w_src, 3'd1);
    end
  end

  // Grant and credit together cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_credits <= CMAX;
      r_err     <= 1'b0;
    end else if (w_gnt && !credit_i) begin
      r_credits <= r_credits - 1'b1;
    end else if (!w_gnt && credit_i) begin
      if (r_credits == CMAX)
        r_err <= 1'b1;
      else
        r_credits <= r_credits + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_src   <= '0;
    end else begin
      r_valid <= w_gnt;
      if (w_gnt) begin
        r_data <= w_sel;
        r_src  <= w_src;
      end
    end
  end

  assign valid_o   = r_valid;
  assign data_o    = r_data;
  assign src_o     = r_src;
  assign credits_o = r_credits;
  assign err_o     = r_err;

endmodule

// File: tb/tb_output_port_arbiter.sv
// Directed bench for output_port_arbiter (DATA_W=32, CREDITS=4).
// Expectations follow the PKT_LOCK_EN setting of the build.
module tb_output_port_arbiter;

  localparam int DW = 32;
  localparam int CR = 4;
  localparam int CW = $clog2(CR + 1);

  logic          clk;
  logic          rst;
  logic [4:0]    req_i;
  logic [5*DW-1:0] data_i;
  logic [4:0]    grant_o;
  logic          credit_i;
  logic          valid_o;
  logic [DW-1:0] data_o;
  logic [2:0]    src_o;
  logic [CW-1:0] credits_o;
  logic          err_o;

  logic [DW-1:0] hd [5];
  logic [DW-1:0] ef [3];

  int vectors;
  int miscompares;

  assign data_i = {hd[4], hd[3], hd[2], hd[1], hd[0]};

  output_port_arbiter #(.DATA_W(DW), .CREDITS(CR)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_i),
    .data_i    (data_i),
    .grant_o   (grant_o),
    .credit_i  (credit_i),
    .valid_o   (valid_o),
    .data_o    (data_o),
    .src_o     (src_o),
    .credits_o (credits_o),
    .err_o     (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_p [5];
    int e_flit;
    vectors     = 0;
    miscompares = 0;
    for (int k = 0; k < 5; k++)
      hd[k] = 32'h8000_00A0 | (k << 8);
    ef[0] = 32'h0000_0E00;
    ef[1] = 32'h0000_0E01;
    ef[2] = 32'h8000_0E02;

    // Reset values
    rst = 1'b1; req_i = '0; credit_i = 1'b0;
    #2;
    chk("rst_valid", valid_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_src", src_o, 0);
    chk("rst_credits", credits_o, CR);
    chk("rst_err", err_o, 0);
    req_i = 5'b11111;
    #1;
    chk("rst_grant", grant_o, 0);
    tick();
    rst = 1'b0;
    credit_i = 1'b1;

    // Round robin with a credit every cycle: N,S,E,W,L,N,S
    for (int i = 0; i < 7; i++) begin
      #2;
      chk("rr_grant", grant_o, 1 << (i % 5));
      tick();
      chk("rr_valid", valid_o, 1);
      chk("rr_src", src_o, i % 5);
      chk("rr_data", data_o, hd[i % 5]);
      chk("rr_credits", credits_o, CR);
    end
    chk("rr_err", err_o, 0);

    // Credit starvation: ptr=2, so E,W,L,N then stop
    credit_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("cr_grant", grant_o, 1 << ((i + 2) % 5));
      tick();
      chk("cr_src", src_o, (i + 2) % 5);
      chk("cr_credits", credits_o, 3 - i);
    end
    #2;
    chk("cr_starved", grant_o, 0);
    tick();
    chk("cr_novalid", valid_o, 0);
    credit_i = 1'b1;
    #2;
    chk("cr_same_cyc", grant_o, 0);
    tick();
    credit_i = 1'b0;
    chk("cr_one", credits_o, 1);
    #2;
    chk("cr_regrant", grant_o, 5'b00010);
    tick();
    chk("cr_regrant_v", valid_o, 1);
    chk("cr_regrant_s", src_o, 1);
    chk("cr_zero", credits_o, 0);
    #2;
    chk("cr_again", grant_o, 0);

    // Grant plus credit at count 2
    req_i = '0; credit_i = 1'b1;
    tick();
    tick();
    chk("gc_two", credits_o, 2);
    req_i = 5'b00100;
    #2;
    chk("gc_grant", grant_o, 5'b00100);
    tick();
    chk("gc_hold", credits_o, 2);

    // Overflow at full count
    req_i = '0;
    tick();
    tick();
    chk("ov_full", credits_o, CR);
    chk("ov_noerr", err_o, 0);
    tick();
    credit_i = 1'b0;
    chk("ov_sat", credits_o, CR);
    chk("ov_err", err_o, 1);
    req_i = 5'b00001;
    tick();
    req_i = '0;
    tick();
    chk("ov_sticky", err_o, 1);
    chk("ov_credits", credits_o, CR - 1);

    // Fresh reset, then move ptr to E via a single-flit S grant
    rst = 1'b1;
    #1;
    chk("rst2_err", err_o, 0);
    tick();
    rst = 1'b0;
    credit_i = 1'b1;
    req_i = 5'b00010;
    tick();
    chk("pre_src", src_o, 1);

    // E sends a 3-flit packet while N and L request
`ifdef PKT_LOCK_EN
    exp_p = '{2, 2, 2, 4, 0};
`else
    exp_p = '{2, 4, 0, 2, 4};
`endif
    e_flit = 0;
    req_i = 5'b10101;
    for (int i = 0; i < 5; i++) begin
      hd[2] = ef[e_flit];
      #2;
      chk("pk_grant", grant_o, 1 << exp_p[i]);
      tick();
      chk("pk_src", src_o, exp_p[i]);
      chk("pk_data", data_o, (exp_p[i] == 2) ? ef[e_flit] : hd[exp_p[i]]);
      if (exp_p[i] == 2 && e_flit < 2) e_flit++;
    end

    // Reset while E holds a non-tail flit in flight
    credit_i = 1'b0;
    hd[2] = ef[0];
    req_i = 5'b00100;
    #2;
    chk("mr_grant", grant_o, 5'b00100);
    tick();
    chk("mr_valid", valid_o, 1);
    chk("mr_cred3", credits_o, CR - 1);
    rst = 1'b1;
    #1;
    chk("mr_rst_valid", valid_o, 0);
    chk("mr_rst_cred", credits_o, CR);
    chk("mr_rst_grant", grant_o, 0);
    tick();
    rst = 1'b0;
    req_i = 5'b11111;
    #2;
    chk("mr_first", grant_o, 5'b00001);
    tick();
    chk("mr_first_src", src_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
